// File: rtl/figan_pkg.sv
// Shared constants for the feature-map output stages: activation selectors
// and the LeakyReLU slope expressed as a right shift.
package figan_pkg;

  localparam int ACT_RELU    = 0;
  localparam int ACT_LEAKY   = 1;
  localparam int ACT_HTANH   = 2;
  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/fmap_act_out_buffer_if.sv
// Stream bundle around the activation output buffer: conv-side input,
// advisory ready, and the framed, backpressured output towards the next layer.
interface fmap_act_out_buffer_if #(
  parameter int DATA_WIDTH = 16
);

  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         ready_out;
  logic                         ready_in;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         row_end;
  logic                         frame_end;
  logic                         overflow;

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, row_end, frame_end, overflow
  );

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out, row_end, frame_end, overflow
  );

endinterface

// File: rtl/stream_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO only
// succeeds when a pop happens in the same cycle.
module stream_sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  input  logic                         i_pop,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]                r_wptr;
  logic [AW-1:0]                r_rptr;
  logic [CW-1:0]                r_count;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_do_push;
  logic                         w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero while empty so the output is clean after reset.
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/fmap_act_out_buffer.sv
// Activation stage after the transposed conv: activation, one register stage,
// FWFT buffer with backpressure, row/frame tagging and sticky overflow.
module fmap_act_out_buffer
  import figan_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int FM_WIDTH   = 14,
  parameter int FM_HEIGHT  = 14,
  parameter int DEPTH      = 32,
  parameter int ACT_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fmap_act_out_buffer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int COL_W = (FM_WIDTH  > 1) ? $clog2(FM_WIDTH)  : 1;
  localparam int ROW_W = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FM_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FM_HEIGHT - 1);
  localparam logic signed [DATA_WIDTH-1:0] POS_ONE = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic signed [DATA_WIDTH-1:0] NEG_ONE = -POS_ONE;

  logic signed [DATA_WIDTH-1:0] w_x;
  logic signed [DATA_WIDTH-1:0] w_act;
  logic                         r_s1_valid;
  logic signed [DATA_WIDTH-1:0] r_s1_data;
  logic signed [DATA_WIDTH-1:0] w_head;
  logic                         w_full;
  logic                         w_empty;
  logic [CNT_W-1:0]             w_count;
  logic                         w_valid;
  logic                         w_pop;
  logic                         r_overflow;
  logic [COL_W-1:0]             r_col;
  logic [ROW_W-1:0]             r_row;
  logic                         w_row_end;

  assign w_x = bus.data_in;

  always_comb begin
    w_act = w_x;
    case (ACT_MODE)
      ACT_RELU:  if (w_x[DATA_WIDTH-1]) w_act = '0;
      ACT_LEAKY: if (w_x[DATA_WIDTH-1]) w_act = w_x >>> LEAKY_SHIFT;
      ACT_HTANH: begin
        if (w_x > POS_ONE)      w_act = POS_ONE;
        else if (w_x < NEG_ONE) w_act = NEG_ONE;
      end
      default:   w_act = w_x;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= bus.valid_in;
      if (bus.valid_in) r_s1_data <= w_act;
    end
  end

  stream_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s1_valid),
    .i_data  (r_s1_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_valid = !w_empty;
  assign w_pop   = w_valid && bus.ready_in;

  // The conv cannot stall, so a full buffer without a same-cycle pop loses the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overflow <= 1'b0;
    else if (r_s1_valid && w_full && !w_pop) r_overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign w_row_end     = w_valid && (r_col == COL_LAST);
  // One slot stays free for the sample already sitting in the stage register.
  assign bus.ready_out = (w_count <= CNT_W'(DEPTH - 2));
  assign bus.valid_out = w_valid;
  assign bus.data_out  = w_head;
  assign bus.row_end   = w_row_end;
  assign bus.frame_end = w_row_end && (r_row == ROW_LAST);
  assign bus.overflow  = r_overflow;

endmodule
